sm_bus_ctrl: RTL
================

// Module: sm_bus_ctrl
// PURPOSE
//  Snooping-bus controller downstream of two per-block MSI coherence FSMs (P0, P1).
//  - Captures each FSM's single-cycle writeMiss/readMiss/writeBack/invalidateOut pulses.
//  - Serialises them onto one shared bus with round-robin arbitration.
//  - Drives fetch/invalidate back to the remote FSM and sequences memory write-back/read.
// PARAMETERS
//  MEM_LAT  4  cycles mem_wr or mem_rd stays high per access (>=1)
// PORTS
//  clock          in   1  single clock, all state on posedge
//  reset_n        in   1  asynchronous, active-low reset
//  write_miss     in   2  [i]=writeMiss pulse from FSM i
//  read_miss      in   2  [i]=readMiss pulse from FSM i
//  write_back     in   2  [i]=writeBack pulse from FSM i
//  invalidate_req in   2  [i]=invalidateOut pulse from FSM i
//  state0         in   2  currentState of FSM 0 (00 I, 01 S, 10 M)
//  state1         in   2  currentState of FSM 1
//  fetch          out  2  [j]=fetch to FSM j, one-cycle pulse
//  invalidate     out  2  [j]=invalidateIn to FSM j, one-cycle pulse
//  mem_wr         out  1  memory write-back in progress
//  mem_rd         out  1  memory read in progress
//  busy           out  1  transaction in flight (state != IDLE)
//  grant_id       out  1  requester owning current transaction
//  done           out  2  [i]=one-cycle completion pulse to requester i
//  protocol_err   out  1  one-cycle pulse: both FSMs in M during SNOOP
// BEHAVIOUR
//  Reset: state=IDLE, pending[1:0]=0, rr pointer=0 (P0 first); all outputs 0.
//  Reset mid-transaction aborts immediately; captured requests are lost.
//  Capture: pending[i] = 4-bit {wm,rm,wb,inv}.
//  - Every posedge ORs the four input pulses into pending[i].
//  - Pending[i] is cleared on the edge requester i is granted.
//  - Pulses arriving on that same edge survive (clear first, then OR).
//  Arbitration (IDLE only): a requester with nonzero pending is eligible.
//  - Both eligible: grant the one != rr; rr <= granted id.
//  - Grant latches the word into txn, sets grant_id, sets busy.
//  - Remote j = 1 - grant_id.
//  FSM states: IDLE, SNOOP, WB, MEM, DONE.
//  - IDLE->SNOOP if txn has wm|rm|inv; else IDLE->WB (pure eviction).
//  - SNOOP, exactly 1 cycle: sample remote state (rM = remote==10).
//    - wm|inv: invalidate[j]=1.
//    - (wm|rm) and rM: fetch[j]=1.
//    - Own state also 10 with rM: protocol_err=1 (continue normally).
//  - SNOOP->WB if txn.wb or ((wm|rm) and rM).
//  - SNOOP->MEM if (wm|rm) and no WB is needed.
//  - SNOOP->DONE otherwise (pure upgrade/invalidate).
//  - WB: mem_wr=1 for exactly MEM_LAT cycles (one pass even if own wb and rM).
//    Then MEM if wm|rm, else DONE.
//  - MEM: mem_rd=1 for exactly MEM_LAT cycles, then DONE.
//  - DONE, 1 cycle: done[grant_id]=1, busy=0 next cycle, return to IDLE.
//    New grant possible on the following IDLE cycle.
//  Latency counter counts 0..MEM_LAT-1 and resets on each WB/MEM entry.
//  mem_wr and mem_rd are never high together.
//  All outputs registered; fetch/invalidate/done/protocol_err are one-cycle pulses.
//  Repeated pulses while pending merge into one request (OR), not queued twice.
// TESTING
//  1 Reset mid-MEM: reset_n low -> all outputs 0 asynchronously; IDLE after release.
//  2 P0 read_miss, state1=01, MEM_LAT=4:
//    SNOOP 1 cyc, no fetch/invalidate; mem_rd 4 cyc; done[0] 1 cyc later.
//  3 P1 write_miss, state0=10:
//    SNOOP fetch[0]=invalidate[0]=1 for 1 cyc; mem_wr 4 cyc; mem_rd 4 cyc; done[1].
//  4 P0 invalidate_req, state1=01:
//    invalidate[1] pulse; no mem_rd/mem_wr; done[0] two cycles after grant.
//  5 P0 and P1 read_miss on same edge after reset: P1 granted first (rr=0).
//    P0 granted after P1's DONE; rr alternates on a further tie.
//  6 P0 write_back+write_miss same edge, state1=00: no fetch.
//    mem_wr 4 cyc then mem_rd 4 cyc; new P0 pulse during grant edge is retained.

Source files
------------

// File: rtl/sm_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sm_bus_ctrl
// Description : Snooping-bus controller that sits behind two MSI coherence
//               FSMs (P0, P1). It captures their request pulses, serialises
//               them onto one shared bus with round-robin arbitration, drives
//               fetch/invalidate to the remote FSM and sequences the memory
//               write-back and read phases.
// Ports       : clock          - single clock, all state on posedge
//               reset_n        - asynchronous active-low reset
//               write_miss     - [i] writeMiss pulse from FSM i
//               read_miss      - [i] readMiss pulse from FSM i
//               write_back     - [i] writeBack pulse from FSM i
//               invalidate_req - [i] invalidateOut pulse from FSM i
//               state0/state1  - current MSI state of FSM 0 / FSM 1
//               fetch          - [j] one-cycle fetch pulse to FSM j
//               invalidate     - [j] one-cycle invalidateIn pulse to FSM j
//               mem_wr         - memory write-back in progress
//               mem_rd         - memory read in progress
//               busy           - transaction in flight
//               grant_id       - requester owning the current transaction
//               done           - [i] one-cycle completion pulse to requester i
//               protocol_err   - one-cycle pulse: both FSMs in M during snoop
// Revision    : 1.0 - initial release
// ============================================================================
module sm_bus_ctrl #(
  parameter int MEM_LAT = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] write_miss,
  input  logic [1:0] read_miss,
  input  logic [1:0] write_back,
  input  logic [1:0] invalidate_req,
  input  logic [1:0] state0,
  input  logic [1:0] state1,
  output logic [1:0] fetch,
  output logic [1:0] invalidate,
  output logic       mem_wr,
  output logic       mem_rd,
  output logic       busy,
  output logic       grant_id,
  output logic [1:0] done,
  output logic       protocol_err
);

  // Request word layout: {wm, rm, wb, inv}
  localparam int c_WM  = 3;
  localparam int c_RM  = 2;
  localparam int c_WB  = 1;
  localparam int c_INV = 0;

  localparam logic [1:0] c_ST_M = 2'b10;

  // Counter width kept at least 1 so MEM_LAT == 1 still elaborates.
  localparam int c_CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SNOOP = 3'd1,
    S_WB    = 3'd2,
    S_MEM   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0][3:0]     r_pend;
  logic                r_rr;
  logic                r_grant_id;
  logic                r_txn_rw;    // latched wm|rm of the granted word
  logic                r_txn_wb;    // latched wb of the granted word
  logic                r_rem_m;     // remote was in M when snooped
  logic [c_CNT_W-1:0]  r_cnt;

  logic [1:0] r_fetch;
  logic [1:0] r_invalidate;
  logic       r_mem_wr;
  logic       r_mem_rd;
  logic       r_busy;
  logic [1:0] r_done;
  logic       r_protocol_err;

  logic [1:0] w_elig;
  logic       w_grant;
  logic       w_gid;
  logic       w_rem_id;
  logic [3:0] w_word;
  logic [1:0] w_rem_state;
  logic [1:0] w_own_state;
  logic       w_rem_m;
  logic       w_own_m;
  logic       w_word_rw;
  logic [1:0] w_clr;
  logic       w_cnt_last;
  logic       w_cnt_load;

  logic [1:0] w_fetch_n;
  logic [1:0] w_inv_n;
  logic [1:0] w_done_n;
  logic       w_perr_n;

  // --------------------------------------------------------------------------
  // Arbitration: only in IDLE. On a tie the requester that was not granted
  // last wins; the pointer always tracks the most recent grant.
  // --------------------------------------------------------------------------
  assign w_elig[0]   = |r_pend[0];
  assign w_elig[1]   = |r_pend[1];
  assign w_grant     = (r_state == S_IDLE) && (|w_elig);
  assign w_gid       = (w_elig == 2'b11) ? ~r_rr : w_elig[1];
  assign w_rem_id    = ~w_gid;
  assign w_word      = w_gid ? r_pend[1] : r_pend[0];
  assign w_rem_state = w_gid ? state0 : state1;
  assign w_own_state = w_gid ? state1 : state0;
  assign w_rem_m     = (w_rem_state == c_ST_M);
  assign w_own_m     = (w_own_state == c_ST_M);
  assign w_word_rw   = w_word[c_WM] | w_word[c_RM];
  assign w_clr       = w_grant ? (w_gid ? 2'b10 : 2'b01) : 2'b00;
  assign w_cnt_last  = (r_cnt == c_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and next-cycle output values. Outputs are registered, so the
  // values computed here appear during the cycle spent in w_next. The snoop
  // pulses are therefore computed on the grant edge from the word being
  // granted and the remote state seen at that edge.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_fetch_n = 2'b00;
    w_inv_n   = 2'b00;
    w_done_n  = 2'b00;
    w_perr_n  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          if (w_word_rw || w_word[c_INV]) begin
            w_next = S_SNOOP;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_SNOOP: begin
        if (r_txn_wb || (r_txn_rw && r_rem_m)) begin
          w_next = S_WB;
        end else if (r_txn_rw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_DONE;
        end
      end
      S_WB: begin
        // A single write-back pass covers both own eviction and remote M data.
        if (w_cnt_last) begin
          w_next = r_txn_rw ? S_MEM : S_DONE;
        end
      end
      S_MEM: begin
        if (w_cnt_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    if ((r_state == S_IDLE) && (w_next == S_SNOOP)) begin
      w_inv_n[w_rem_id]   = w_word[c_WM] | w_word[c_INV];
      w_fetch_n[w_rem_id] = w_word_rw & w_rem_m;
      w_perr_n            = w_own_m & w_rem_m;
    end

    if (w_next == S_DONE) begin
      w_done_n[r_grant_id] = 1'b1;
    end
  end

  // The latency counter restarts whenever WB or MEM is entered.
  assign w_cnt_load = ((w_next == S_WB)  && (r_state != S_WB)) ||
                      ((w_next == S_MEM) && (r_state != S_MEM));

  // --------------------------------------------------------------------------
  // Request capture, transaction latch, latency counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pend     <= '0;
      r_rr       <= 1'b0;
      r_grant_id <= 1'b0;
      r_txn_rw   <= 1'b0;
      r_txn_wb   <= 1'b0;
      r_rem_m    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      // Clear on grant first, then OR in any pulse arriving on the same edge.
      for (int i = 0; i < 2; i++) begin
        r_pend[i] <= (w_clr[i] ? 4'b0000 : r_pend[i]) |
                     {write_miss[i], read_miss[i], write_back[i], invalidate_req[i]};
      end

      if (w_grant) begin
        r_grant_id <= w_gid;
        r_rr       <= w_gid;
        r_txn_rw   <= w_word_rw;
        r_txn_wb   <= w_word[c_WB];
        r_rem_m    <= w_rem_m;
      end

      if (w_cnt_load) begin
        r_cnt <= '0;
      end else if ((r_state == S_WB) || (r_state == S_MEM)) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch        <= 2'b00;
      r_invalidate   <= 2'b00;
      r_mem_wr       <= 1'b0;
      r_mem_rd       <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 2'b00;
      r_protocol_err <= 1'b0;
    end else begin
      r_fetch        <= w_fetch_n;
      r_invalidate   <= w_inv_n;
      r_mem_wr       <= (w_next == S_WB);
      r_mem_rd       <= (w_next == S_MEM);
      r_busy         <= (w_next != S_IDLE);
      r_done         <= w_done_n;
      r_protocol_err <= w_perr_n;
    end
  end

  assign fetch        = r_fetch;
  assign invalidate   = r_invalidate;
  assign mem_wr       = r_mem_wr;
  assign mem_rd       = r_mem_rd;
  assign busy         = r_busy;
  assign grant_id     = r_grant_id;
  assign done         = r_done;
  assign protocol_err = r_protocol_err;

endmodule
`default_nettype wire
